// File: rtl/ahb_sim_ctrl_slv.sv
// AHB-Lite simulation control responder: console character FIFO, pass/fail magic words, STATUS read-back.
// Optional watchdog that forces a fail verdict after a retire-free interval: define SIM_CTRL_WDOG_EN.
module ahb_sim_ctrl_slv #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [11:0] DATA_OFS    = 12'hFF8,
  parameter logic [11:0] STAT_OFS    = 12'hFFC,
  parameter int          TIMEOUT_CYC = 5000
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        char_vld,
  output logic [7:0]  char_data,
  input  logic        char_rdy,
  output logic        sim_done,
  output logic        sim_pass
`ifdef SIM_CTRL_WDOG_EN
  ,
  input  logic        retire
`endif
);

  localparam int               AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW:0]      CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_DPH, S_STALL, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            vld_p1, wr_p1;
  logic [11:0]     ofs_p1;
  logic [2:0]      size_p1;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            verdict;
  logic            accept_p0, wr_data, rd_stat, magic, pop, push, full, empty;
  logic            verdict_set, verdict_val, done_set, timeout;
  logic [8:0]      cnt_ext;
  logic            unused_ok;

  function automatic logic is_pass(input logic [31:0] w);
    return (w == 32'h0000_0FFF) || (w == 32'hFFFF_0000);
  endfunction

  function automatic logic is_fail(input logic [31:0] w);
    return (w == 32'h0000_0EEE) || (w == 32'hEEEE_0000);
  endfunction

  function automatic logic [31:0] status_word(input logic [7:0] c, input logic e, input logic f,
                                              input logic p, input logic d);
    return {16'b0, c, 4'b0, e, f, p, d};
  endfunction

  // Address phase -> data phase
  assign accept_p0 = hsel & hready & htrans[1];

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      ofs_p1  <= '0;
      size_p1 <= '0;
    end else if (hready) begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        wr_p1   <= hwrite;
        ofs_p1  <= haddr[11:0];
        size_p1 <= hsize;
      end
    end
  end

  // Data phase decode
  assign wr_data = vld_p1 & wr_p1 & (ofs_p1 == DATA_OFS);
  assign rd_stat = vld_p1 & ~wr_p1 & (ofs_p1 == STAT_OFS);
  assign magic   = is_pass(hwdata) | is_fail(hwdata);
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign pop     = char_vld & char_rdy;
  assign cnt_ext = 9'(count);

`ifdef SIM_CTRL_WDOG_EN
  logic [31:0] wdog_cnt;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst)        wdog_cnt <= '0;
    else if (retire) wdog_cnt <= '0;
    else             wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign timeout = (wdog_cnt == TMO_LAST) & ~retire;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO_LAST;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    hready_resp = 1'b1;
    push        = 1'b0;
    verdict_set = 1'b0;
    verdict_val = 1'b0;
    done_set    = 1'b0;
    case (state)
      S_IDLE, S_DPH: begin
        state_nxt = accept_p0 ? S_DPH : S_IDLE;
        if (wr_data) begin
          if (magic) begin
            verdict_set = 1'b1;
            verdict_val = is_pass(hwdata);
            state_nxt   = S_DRAIN;
          end else if (full && !pop) begin
            hready_resp = 1'b0;
            state_nxt   = S_STALL;
          end else begin
            push = 1'b1;
          end
        end
      end
      S_STALL: begin
        hready_resp = pop;
        if (pop) begin
          push      = 1'b1;
          state_nxt = accept_p0 ? S_DPH : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (empty) begin
          done_set  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_DONE;
    endcase
    // A magic word seen this cycle wins over the watchdog
    if (timeout && !verdict_set && (state != S_DRAIN) && (state != S_DONE)) begin
      verdict_set = 1'b1;
      verdict_val = 1'b0;
      if (empty && !push) begin
        done_set  = 1'b1;
        state_nxt = S_DONE;
      end else begin
        state_nxt = S_DRAIN;
      end
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state    <= S_IDLE;
      verdict  <= 1'b0;
      sim_done <= 1'b0;
      sim_pass <= 1'b0;
    end else begin
      state <= state_nxt;
      if (verdict_set) verdict <= verdict_val;
      if (done_set) begin
        sim_done <= 1'b1;
        sim_pass <= verdict_set ? verdict_val : verdict;
      end
    end
  end

  // Character FIFO
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr] <= hwdata[7:0];
  end

  assign char_vld  = ~empty;
  assign char_data = mem[rd_ptr];
  assign hresp     = 2'b00;

  always_comb begin
    hrdata = '0;
    if (rd_stat) hrdata = status_word(cnt_ext[7:0], empty, full, sim_pass, sim_done);
  end

  assign unused_ok = ^{haddr[31:12], htrans[0], size_p1};

endmodule
